demux_tdm_14: RTL and testbench
===============================

// Module: demux_tdm_14
// PURPOSE
//  Receive end of the 4-channel TDM link. The transmit side is a 4:1 mux driven by a
//  2-bit slot select {A,B}, which sends ch0,ch1,ch2,ch3 bit-interleaved, MSB first.
//  This block is the demultiplexer. It tracks the slot, steers each incoming bit into
//  its channel shift register, and presents 4 parallel words per frame with a 1-cycle
//  valid strobe. It sits between the serial line input and the word-level consumers.
// PARAMETERS
//  WIDTH      8  bits per channel word; frame length = 4*WIDTH valid bits
//  BIT_CNT_W  3  width of the per-channel bit counter; 2**BIT_CNT_W >= WIDTH (checked in sim)
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      reset, asynchronous, active-low
//  din         in   1      serial data bit
//  din_valid   in   1      din is sampled only when 1; gaps allowed anywhere
//  frame_sync  in   1      qualified by din_valid; marks the bit as ch0 MSB (frame start)
//  Y0..Y3      out  WIDTH  last complete word for channels 0..3
//  out_valid   out  1      1-cycle pulse: Y0..Y3 updated this cycle
//  A, B        out  1      current slot select (A = MSB), same meaning as the mux select
//  sync_err    out  1      1-cycle pulse: frame_sync seen mid-frame
// BEHAVIOUR
//  Reset (async assert, sync deassert by the system):
//   - state=HUNT; slot=0; bit_cnt=0.
//   - Y0..Y3, out_valid, sync_err, A, B, and all shift registers = 0.
//  FSM states: HUNT, RECV.
//   HUNT:
//    - din_valid & ~frame_sync: bit discarded; no output change.
//    - din_valid & frame_sync: bit shifts into ch0 register; slot->1; go to RECV.
//   RECV (each din_valid):
//    - Bit shifts into ch[slot] register, MSB first (shift left, LSB in).
//    - slot increments mod 4. bit_cnt increments when slot wraps 3->0.
//    - Last bit (slot==3 & bit_cnt==WIDTH-1):
//      - Y0..Y3 take the 4 assembled words at the next edge; out_valid=1 for that cycle.
//      - slot=0, bit_cnt=0; go to HUNT. The next frame needs frame_sync on its first bit.
//    - frame_sync on any bit in RECV (including the last) is a mid-frame sync:
//      - sync_err=1 for one cycle; partial frame dropped (no out_valid, Y unchanged).
//      - Shift registers cleared, then this bit is taken as ch0 MSB of a new frame:
//        slot->1, bit_cnt=0, stay in RECV.
//  Timing and output rules:
//   - Cycles with din_valid=0: no state change; A, B, and registers hold.
//   - Latency: out_valid rises 1 clk after the edge that sampled the last bit.
//   - Y0..Y3 hold between frames; never partially updated.
//   - {A,B} = registered slot: the slot the next valid bit will be written to.
//     Shows 0 in HUNT.
//   - Reset mid-frame: all state and outputs clear immediately. No out_valid or
//     sync_err is generated for the aborted frame.
//   - out_valid and sync_err are never both 1 in the same cycle.
// STRUCTURE
//  - Shared include demux_defs.vh: HUNT/RECV state encodings, slot width (2),
//    channel count (4). The same file is used by the transmit-side sequencer.
//  - Sub-module demux_shift_ch (x4): WIDTH-bit shift register with clk, rst_n,
//    en, clr, din, q. Its en comes from a 2->4 decode of slot & din_valid &
//    state-dependent qualify.
//  - Top level holds the FSM, slot/bit counters, and the output registers.
// TESTING (WIDTH=8)
//  1. Nominal frame: sync + 32 bits, interleaved bytes ch0..3 = A5,3C,FF,01
//     -> out_valid 1 clk after bit 32; Y0=A5 Y1=3C Y2=FF Y3=01; sync_err=0.
//  2. Same frame with din_valid=0 for 3 cycles after bits 5 and 20
//     -> identical Y values; {A,B} holds during gaps; out_valid once.
//  3. Frame of 66,99,0F,F0 with frame_sync again on bit 11
//     -> sync_err pulse; no out_valid.
//     A new full frame starting at that bit, 12,34,56,78 -> Y=12,34,56,78.
//  4. In HUNT, 7 bits without sync, then a sync frame of 00,FF,00,FF
//     -> the 7 bits are ignored; Y=00,FF,00,FF.
//  5. rst_n low for 1 cycle after bit 17 of a frame, then a full frame of 11,22,33,44
//     -> outputs 0 during reset; no pulses; Y=11,22,33,44 afterwards.
//  6. Two back-to-back frames, the second's sync on the cycle right after the first's last bit
//     -> two out_valid pulses 32 valid bits apart; {A,B} walks 0,1,2,3 per slot.

Source files
------------

// File: rtl/demux_tdm_14_pkg.sv
// Shared definitions for the 4-channel TDM link: state encodings, slot geometry, slot decode.
package demux_tdm_14_pkg;

    localparam int unsigned SLOT_W = 2;
    localparam int unsigned NUM_CH = 4;

    // Receiver FSM states
    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    typedef logic [SLOT_W-1:0] slot_t;

    // One-hot channel enable for the given slot, all-zero when not enabled
    function automatic logic [NUM_CH-1:0] slot_decode(input slot_t s, input logic en);
        return en ? (NUM_CH'(1) << s) : '0;
    endfunction

endpackage

// File: rtl/demux_tdm_14_shift_ch.sv
// Per-channel MSB-first shift register. A clear that coincides with an enable
// restarts the register with the incoming bit as its first bit.
module demux_tdm_14_shift_ch #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // Shift left with LSB in; clear has priority over a plain shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= en ? {{(WIDTH-1){1'b0}}, din} : '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/demux_tdm_14.sv
// Receive-side demultiplexer of the 4-channel bit-interleaved TDM link.
// Tracks the slot, steers bits into per-channel shift registers and presents
// all four words at once with a one-cycle valid strobe.
module demux_tdm_14
    import demux_tdm_14_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned BIT_CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] Y0,
    output logic [WIDTH-1:0] Y1,
    output logic [WIDTH-1:0] Y2,
    output logic [WIDTH-1:0] Y3,
    output logic             out_valid,
    output logic             A,
    output logic             B,
    output logic             sync_err
);

    if ((1 << BIT_CNT_W) < WIDTH) begin : g_bad_bit_cnt_w
        $error("BIT_CNT_W too small for WIDTH");
    end

    logic [0:0]           state;
    slot_t                slot;
    logic [BIT_CNT_W-1:0] bit_cnt;

    logic                 take;
    logic                 resync;
    logic                 last_bit;
    slot_t                ch_sel;
    logic [NUM_CH-1:0]    ch_en;
    logic [WIDTH-1:0]     sh [NUM_CH];

    // Bit steering: a sync bit always lands in ch0; HUNT only accepts sync bits
    always_comb begin
        take     = din_valid & ((state == RECV) | frame_sync);
        resync   = din_valid & frame_sync & (state == RECV);
        last_bit = din_valid & ~frame_sync & (state == RECV)
                   & (slot == slot_t'(NUM_CH - 1))
                   & (bit_cnt == BIT_CNT_W'(WIDTH - 1));
        ch_sel   = frame_sync ? '0 : slot;
        ch_en    = slot_decode(ch_sel, take);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        demux_tdm_14_shift_ch #(
            .WIDTH (WIDTH)
        ) u_shift (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (ch_en[i]),
            .clr   (resync),
            .din   (din),
            .q     (sh[i])
        );
    end

    // FSM plus slot / bit counters; nothing moves on cycles without din_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= HUNT;
            slot    <= '0;
            bit_cnt <= '0;
        end else if (din_valid) begin
            if (frame_sync) begin
                // Frame start in HUNT, or mid-frame resync in RECV: both restart at slot 1
                state   <= RECV;
                slot    <= slot_t'(1);
                bit_cnt <= '0;
            end else if (state == RECV) begin
                if (last_bit) begin
                    state   <= HUNT;
                    slot    <= '0;
                    bit_cnt <= '0;
                end else begin
                    slot <= slot + 1'b1;
                    if (slot == slot_t'(NUM_CH - 1)) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Output words and strobes; ch3's final bit is still on din when the frame completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y0        <= '0;
            Y1        <= '0;
            Y2        <= '0;
            Y3        <= '0;
            out_valid <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            out_valid <= last_bit;
            sync_err  <= resync;
            if (last_bit) begin
                Y0 <= sh[0];
                Y1 <= sh[1];
                Y2 <= sh[2];
                Y3 <= {sh[3][WIDTH-2:0], din};
            end
        end
    end

    assign A = slot[1];
    assign B = slot[0];

endmodule

// File: tb/tb_demux_tdm_14.sv
// Scoreboard bench for demux_tdm_14: stimulus pushes expected words, a negedge
// monitor pops and compares whenever out_valid is presented.
module tb_demux_tdm_14;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic [7:0] y0, y1, y2, y3;
    logic       out_valid, a, b, sync_err;

    int checks = 0;
    int passed = 0;
    int exp_serr = 0;
    int got_serr = 0;
    int both_cnt = 0;
    int vbits = 0;
    longint last_edge = -100;
    logic [31:0] exp_q[$];
    int pulse_bits[$];

    demux_tdm_14 #(
        .WIDTH     (8),
        .BIT_CNT_W (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .Y0         (y0),
        .Y1         (y1),
        .Y2         (y2),
        .Y3         (y3),
        .out_valid  (out_valid),
        .A          (a),
        .B          (b),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compare presented words against the scoreboard queue
    always @(negedge clk) begin
        if (out_valid && sync_err) both_cnt++;
        if (sync_err) got_serr++;
        if (out_valid) begin
            pulse_bits.push_back(vbits);
            check("latency", 32'($time - last_edge), 32'd5);
            check("out_valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("Y_words", {y0, y1, y2, y3}, exp_q.pop_front());
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic d, input logic s, input bit last,
                            input logic [1:0] exp_ab);
        din        = d;
        frame_sync = s;
        din_valid  = 1'b1;
        @(posedge clk);
        vbits++;
        if (last) last_edge = $time;
        #1;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        check("slot_AB", {30'd0, a, b}, {30'd0, exp_ab});
    endtask

    // Words packed ch0 in [31:24]; gaps of 3 idle cycles after bits g1/g2; stop early if stop>0
    task automatic send_frame(input logic [31:0] w, input int g1, input int g2, input int stop);
        for (int n = 1; n <= 32; n++) begin
            int ch;
            int bi;
            logic [7:0] wd;
            logic [1:0] eab;
            if (stop != 0 && n > stop) break;
            ch  = (n - 1) % 4;
            bi  = 7 - (n - 1) / 4;
            wd  = 8'(w >> (8 * (3 - ch)));
            eab = (n == 32) ? 2'd0 : 2'(n % 4);
            send_bit(wd[bi], n == 1, n == 32, eab);
            if (n == g1 || n == g2) begin
                repeat (3) begin
                    idle(1);
                    check("AB_hold_gap", {30'd0, a, b}, {30'd0, eab});
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_Y", {y0, y1, y2, y3}, 32'h0);
        check("reset_pulses", {30'd0, out_valid, sync_err}, 32'h0);
        check("reset_AB", {30'd0, a, b}, 32'h0);
        rst_n = 1'b1;
        idle(2);

        // 1. nominal frame
        exp_q.push_back(32'hA53CFF01);
        send_frame(32'hA53CFF01, 0, 0, 0);
        idle(2);

        // 2. same frame with gaps after bits 5 and 20
        exp_q.push_back(32'hA53CFF01);
        send_frame(32'hA53CFF01, 5, 20, 0);
        idle(2);

        // 3. resync on bit 11 aborts 66990FF0 and starts 12345678
        send_frame(32'h66990FF0, 0, 0, 10);
        exp_serr++;
        exp_q.push_back(32'h12345678);
        send_frame(32'h12345678, 0, 0, 0);
        idle(2);
        check("sync_err_count_t3", 32'(got_serr), 32'(exp_serr));

        // 4. bits in HUNT without sync are discarded
        for (int i = 0; i < 7; i++) send_bit(1'($urandom), 1'b0, 1'b0, 2'd0);
        exp_q.push_back(32'h00FF00FF);
        send_frame(32'h00FF00FF, 0, 0, 0);
        idle(2);

        // 5. reset mid-frame after bit 17
        send_frame(32'hDEADBEEF, 0, 0, 17);
        rst_n = 1'b0;
        #1;
        check("midreset_Y", {y0, y1, y2, y3}, 32'h0);
        check("midreset_AB", {30'd0, a, b}, 32'h0);
        check("midreset_pulses", {30'd0, out_valid, sync_err}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back(32'h11223344);
        send_frame(32'h11223344, 0, 0, 0);
        idle(2);

        // 6. back-to-back frames
        pulse_bits.delete();
        exp_q.push_back(32'hC35A9669);
        exp_q.push_back(32'h0F1E2D3C);
        send_frame(32'hC35A9669, 0, 0, 0);
        send_frame(32'h0F1E2D3C, 0, 0, 0);
        idle(3);
        check("b2b_pulse_count", 32'(pulse_bits.size()), 32'd2);
        if (pulse_bits.size() == 2)
            check("b2b_spacing", 32'(pulse_bits[1] - pulse_bits[0]), 32'd32);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("sync_err_total", 32'(got_serr), 32'(exp_serr));
        check("no_simultaneous_pulses", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
